// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - bit-reversed to natural order reorder stage with ping-pong frame buffers
//
// Purpose: accepts FFT bins in bit-reversed order from the last SDF unit and
// emits each frame in natural order. Two N-entry complex banks alternate so the
// writer fills one frame while the reader drains the previous one.
//
// Ports:
//   clock   master clock
//   reset   synchronous active-low reset
//   di_en   input sample valid
//   di_re   input real part (signed)
//   di_im   input imag part (signed)
//   adjust  frame mode, latched on the first sample of a frame (0: N points, 1: N/4 points)
//   do_en   output sample valid
//   do_re   output real part (signed)
//   do_im   output imag part (signed)
//   do_idx  natural-order bin index of the current output
//   ovf     sticky flag: an input sample was dropped because its bank was still unread

module fft_bitrev_reorder #(
    parameter  int N     = 64,
    parameter  int WIDTH = 16,
    localparam int LOG_N = $clog2(N)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    input  logic                    adjust,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im,
    output logic [LOG_N-1:0]        do_idx,
    output logic                    ovf
);

    localparam logic [LOG_N-1:0] LAST_FULL = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] LAST_QTR  = LOG_N'(N / 4 - 1);
    localparam logic [LOG_N-1:0] CNT_ONE   = LOG_N'(1);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Reverse all LOG_N bits in full mode; in quarter mode only the low
    // LOG_N-2 bits are reversed and the upper two stay zero.
    function automatic logic [LOG_N-1:0] bitrev_addr(input logic [LOG_N-1:0] a,
                                                     input logic             quarter);
        logic [LOG_N-1:0] r;
        r = '0;
        if (quarter) begin
            for (int i = 0; i < LOG_N - 2; i++) begin
                r[i] = a[LOG_N-3-i];
            end
        end else begin
            for (int i = 0; i < LOG_N; i++) begin
                r[i] = a[LOG_N-1-i];
            end
        end
        return r;
    endfunction

    // Storage: bank select is the MSB of the address.
    logic [2*WIDTH-1:0] mem_q [0:2*N-1];
    logic [2*WIDTH-1:0] ram_q;

    // Write side state
    logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       mode_q, mode_d;
    logic             ovf_q, ovf_d;

    // Reader state
    rd_state_e        rd_state_q, rd_state_d;
    logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_bank_q, rd_bank_d;

    // Read pipeline
    logic             s1_vld_q;
    logic [LOG_N-1:0] s1_idx_q;
    logic             do_en_q;
    logic [WIDTH-1:0] do_re_q, do_im_q;
    logic [LOG_N-1:0] do_idx_q;

    // Write-side combinational helpers
    logic             wr_mode;
    logic [LOG_N-1:0] wr_last_cnt;
    logic [LOG_N-1:0] wr_addr;
    logic             wr_accept;
    logic             wr_drop;

    // Reader combinational helpers
    logic [LOG_N-1:0] rd_last_cnt;
    logic             issue_vld;
    logic [LOG_N-1:0] issue_cnt;
    logic             issue_last;

    // The first sample of a frame uses the live adjust value; later samples use
    // the mode latched for that bank, so mid-frame changes have no effect.
    assign wr_mode     = (wr_cnt_q == '0) ? adjust : mode_q[wr_bank_q];
    assign wr_last_cnt = wr_mode ? LAST_QTR : LAST_FULL;
    assign wr_addr     = bitrev_addr(wr_cnt_q, wr_mode);
    assign wr_accept   = di_en && !full_q[wr_bank_q];
    assign wr_drop     = di_en && full_q[wr_bank_q];

    assign rd_last_cnt = mode_q[rd_bank_q] ? LAST_QTR : LAST_FULL;

    // ------------------------------------------------------------------
    // Write-side and bank flag next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;

        // Reader releases its bank on the final read; the writer can only be
        // finishing the other bank, so the two updates never collide.
        if (issue_last) begin
            full_d[rd_bank_q] = 1'b0;
        end

        if (wr_accept) begin
            if (wr_cnt_q == '0) begin
                mode_d[wr_bank_q] = adjust;
            end
            if (wr_cnt_q == wr_last_cnt) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
            end
        end

        if (wr_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            mode_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Reader FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_bank_q  <= rd_bank_d;
        end
    end

    // ------------------------------------------------------------------
    // Reader FSM: output logic
    // ------------------------------------------------------------------
    // IDLE issues bin 0 in the same cycle it sees a full bank, which is what
    // gives the two-edge latency from the last write to the first output.
    always_comb begin
        issue_vld  = 1'b0;
        issue_cnt  = '0;
        issue_last = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                issue_vld = full_q[rd_bank_q];
                issue_cnt = '0;
            end
            RD_READ: begin
                issue_vld = 1'b1;
                issue_cnt = rd_cnt_q;
            end
            default: begin
                issue_vld = 1'b0;
                issue_cnt = '0;
            end
        endcase
        issue_last = issue_vld && (issue_cnt == rd_last_cnt);
    end

    // ------------------------------------------------------------------
    // Reader FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        if (issue_vld) begin
            if (issue_last) begin
                rd_bank_d  = ~rd_bank_q;
                rd_cnt_d   = '0;
                // Chain straight into the other bank if it is already waiting.
                rd_state_d = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
            end else begin
                rd_cnt_d   = issue_cnt + CNT_ONE;
                rd_state_d = RD_READ;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame storage: write port and synchronous read port
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_q[{wr_bank_q, wr_addr}] <= {di_re, di_im};
        end
        ram_q <= mem_q[{rd_bank_q, issue_cnt}];
    end

    // ------------------------------------------------------------------
    // Read pipeline: valid/index follow the RAM stage, then the output register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            do_en_q  <= 1'b0;
            do_re_q  <= '0;
            do_im_q  <= '0;
            do_idx_q <= '0;
        end else begin
            s1_vld_q <= issue_vld;
            if (issue_vld) begin
                s1_idx_q <= issue_cnt;
            end
            do_en_q <= s1_vld_q;
            if (s1_vld_q) begin
                do_re_q  <= ram_q[2*WIDTH-1:WIDTH];
                do_im_q  <= ram_q[WIDTH-1:0];
                do_idx_q <= s1_idx_q;
            end
        end
    end

    assign do_en  = do_en_q;
    assign do_re  = do_re_q;
    assign do_im  = do_im_q;
    assign do_idx = do_idx_q;
    assign ovf    = ovf_q;

endmodule
